// File: rtl/i2s_rx.sv
// Standard-format I2S slave receiver: oversamples sclk/lrclk/sdata in the clk
// domain and delivers left/right PCM pairs with a one-cycle valid strobe.
module i2s_rx #(
    parameter int AUDIO_DW = 16,
    parameter int TIMEOUT  = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sclk,
    input  logic                lrclk,
    input  logic                sdata,
    output logic [AUDIO_DW-1:0] left_chan,
    output logic [AUDIO_DW-1:0] right_chan,
    output logic                sample_valid,
    output logic                frame_err,
    output logic                locked
);

    localparam logic [0:0] ST_HUNT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;
    localparam int         IW      = $clog2(TIMEOUT + 1);
    localparam logic [5:0] DW6     = 6'(AUDIO_DW);

    logic                sclk_m, sclk_s, sclk_h;
    logic                lr_m, lr_s;
    logic                sd_m, sd_s;
    logic [0:0]          state;
    logic                ws_prev;
    logic [4:0]          bcnt;
    logic [AUDIO_DW-1:0] shreg;
    logic [AUDIO_DW-1:0] left_hold;
    logic                left_ok;
    logic [1:0]          good_pairs;
    logic [IW-1:0]       idle_cnt;

    logic                rise, boundary, take, full, timeout, pair_done;
    logic [AUDIO_DW-1:0] word;

    always_comb begin
        rise      = sclk_s & ~sclk_h;
        boundary  = rise & (lr_s != ws_prev);
        take      = {1'b0, bcnt} < DW6;
        // bcnt + 1 bits seen in this word, boundary bit included
        full      = ({1'b0, bcnt} + 6'd1) >= DW6;
        word      = take ? {shreg[AUDIO_DW-2:0], sd_s} : shreg;
        timeout   = ~rise & (idle_cnt == IW'(TIMEOUT));
        // right word closes the pair, so its validity is "full" at this boundary
        pair_done = boundary & (state == ST_RUN) & ws_prev & full & left_ok;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_m       <= 1'b0;
            sclk_s       <= 1'b0;
            sclk_h       <= 1'b0;
            lr_m         <= 1'b0;
            lr_s         <= 1'b0;
            sd_m         <= 1'b0;
            sd_s         <= 1'b0;
            state        <= ST_HUNT;
            ws_prev      <= 1'b0;
            bcnt         <= '0;
            shreg        <= '0;
            left_hold    <= '0;
            left_ok      <= 1'b0;
            good_pairs   <= '0;
            idle_cnt     <= '0;
            left_chan    <= '0;
            right_chan   <= '0;
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
            locked       <= 1'b0;
        end else begin
            sclk_m       <= sclk;
            sclk_s       <= sclk_m;
            sclk_h       <= sclk_s;
            lr_m         <= lrclk;
            lr_s         <= lr_m;
            sd_m         <= sdata;
            sd_s         <= sd_m;
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;

            if (rise) begin
                idle_cnt <= '0;
                ws_prev  <= lr_s;
            end else if (idle_cnt != IW'(TIMEOUT)) begin
                idle_cnt <= idle_cnt + IW'(1);
            end

            // link went quiet: drop lock and resynchronise on the next boundary
            if (timeout) begin
                state      <= ST_HUNT;
                locked     <= 1'b0;
                good_pairs <= '0;
                left_ok    <= 1'b0;
            end

            if (rise) begin
                if (boundary) begin
                    bcnt  <= '0;
                    shreg <= '0;
                    if (state == ST_HUNT) begin
                        state <= ST_RUN;
                    end else begin
                        if (!full) begin
                            frame_err  <= 1'b1;
                            good_pairs <= '0;
                            locked     <= 1'b0;
                        end
                        if (ws_prev) begin
                            left_ok <= 1'b0;
                        end else begin
                            left_ok <= full;
                            if (full)
                                left_hold <= word;
                        end
                        if (pair_done) begin
                            left_chan    <= left_hold;
                            right_chan   <= word;
                            sample_valid <= 1'b1;
                            if (good_pairs != 2'd2)
                                good_pairs <= good_pairs + 2'd1;
                            if (good_pairs != 2'd0)
                                locked <= 1'b1;
                        end
                    end
                end else begin
                    if (bcnt != 5'd31)
                        bcnt <= bcnt + 5'd1;
                    if (take)
                        shreg <= word;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: a word-level model predicts delivered pairs and
// framing errors; one compare process checks the DUT every clk.
module tb_i2s_rx;

    localparam int DW      = 16;
    localparam int TIMEOUT = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          sclk = 1'b1;
    logic          lrclk = 1'b0;
    logic          sdata = 1'b0;
    logic [DW-1:0] left_chan, right_chan;
    logic          sample_valid, frame_err, locked;

    i2s_rx #(.AUDIO_DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .sclk(sclk), .lrclk(lrclk), .sdata(sdata),
        .left_chan(left_chan), .right_chan(right_chan),
        .sample_valid(sample_valid), .frame_err(frame_err), .locked(locked)
    );

    always #5 clk = ~clk;

    // ---------------- model state (written by the driver only) ----------------
    logic [DW-1:0] exp_l [0:63];
    logic [DW-1:0] exp_r [0:63];
    int            exp_wr = 0;
    int            err_exp = 0;
    logic          m_run = 1'b0;
    logic [DW-1:0] m_hold [0:1];
    logic          m_ok [0:1];
    logic          cur_ch = 1'b0;
    int            cur_len = 0;
    logic [31:0]   cur_val = '0;
    logic          pend = 1'b0;
    int            lit_seq = 0;
    int            lit_sel = 0;
    logic [31:0]   lit_exp = '0;

    // ---------------- compare state (written by the compare process only) -----
    int            rd = 0;
    int            err_seen = 0;
    int            lit_done = 0;
    int            n_chk = 0;
    int            n_pass = 0;
    logic [DW-1:0] m_last_l = '0;
    logic [DW-1:0] m_last_r = '0;

    // A word is judged when the opposite channel starts; the first word after
    // reset or a timeout only serves to find the frame alignment.
    task automatic model_word_end(input logic ch, input int len, input logic [31:0] val);
        if (!m_run) begin
            m_run = 1'b1;
        end else begin
            if (len >= DW) begin
                m_hold[ch] = val[31 -: DW];
                m_ok[ch]   = 1'b1;
            end else begin
                err_exp++;
                m_ok[0] = 1'b0;
                m_ok[1] = 1'b0;
            end
            if (ch) begin
                if (m_ok[0] && m_ok[1]) begin
                    exp_l[exp_wr] = m_hold[0];
                    exp_r[exp_wr] = m_hold[1];
                    exp_wr++;
                end
                m_ok[0] = 1'b0;
                m_ok[1] = 1'b0;
            end
        end
    endtask

    task automatic model_resync();
        m_run   = 1'b0;
        m_ok[0] = 1'b0;
        m_ok[1] = 1'b0;
    endtask

    // Standard I2S: data lags the word select by one bit slot.
    task automatic emit_slot(input logic ch, input logic b);
        sclk  = 1'b0;
        lrclk = ch;
        sdata = pend;
        pend  = b;
        #40;
        sclk  = 1'b1;
        #40;
    endtask

    task automatic emit_word(input logic ch, input int len, input logic [31:0] val);
        logic [31:0] v;
        v = val;
        if (ch != cur_ch)
            model_word_end(cur_ch, cur_len, cur_val);
        for (int k = 0; k < len; k++)
            emit_slot(ch, (k < 32) ? v[31-k] : 1'b0);
        cur_ch  = ch;
        cur_len = len;
        cur_val = val;
    endtask

    // sel: 0 left_chan, 1 right_chan, 2 locked, 3 frame_err count, 4 pairs still expected
    task automatic lit(input int sel, input logic [31:0] e);
        lit_sel = sel;
        lit_exp = e;
        lit_seq++;
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want)
            n_pass++;
        else
            $display("FAIL %s: got %h want %h", name, got, want);
    endtask

    // ---------------- compare process ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("reset_zero", {left_chan, right_chan}, '0);
                chk("reset_flags", {29'd0, sample_valid, frame_err, locked}, 32'd0);
                m_last_l = '0;
                m_last_r = '0;
            end else begin
                if (sample_valid) begin
                    n_chk++;
                    if (rd == exp_wr) begin
                        $display("FAIL unexpected_pair: got L=%h R=%h want no sample_valid", left_chan, right_chan);
                    end else begin
                        n_pass++;
                        chk("pair_left", {16'd0, left_chan}, {16'd0, exp_l[rd]});
                        chk("pair_right", {16'd0, right_chan}, {16'd0, exp_r[rd]});
                        m_last_l = exp_l[rd];
                        m_last_r = exp_r[rd];
                        rd++;
                    end
                    chk("valid_vs_err", {31'd0, frame_err}, 32'd0);
                end else begin
                    chk("hold", {left_chan, right_chan}, {m_last_l, m_last_r});
                end
                if (frame_err) begin
                    chk("err_expected", {31'd0, err_seen < err_exp}, 32'd1);
                    err_seen++;
                end
                if (lit_seq != lit_done) begin
                    case (lit_sel)
                        0: chk("lit_left", {16'd0, left_chan}, lit_exp);
                        1: chk("lit_right", {16'd0, right_chan}, lit_exp);
                        2: chk("lit_locked", {31'd0, locked}, lit_exp);
                        3: chk("lit_err_count", err_seen, lit_exp);
                        default: chk("lit_pending", exp_wr - rd, lit_exp);
                    endcase
                    lit_done = lit_seq;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        m_ok[0] = 1'b0;
        m_ok[1] = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset = 1'b0;
        repeat (4) @(negedge clk);

        // nominal 16-bit slots; a dummy right word aligns the receiver
        emit_word(1'b1, 16, 32'h0000_0000);
        emit_word(1'b0, 16, 32'hA5C3_0000);
        emit_word(1'b1, 16, 32'h3C5A_0000);
        emit_word(1'b0, 16, 32'hA5C3_0000);
        lit(0, 32'hA5C3);
        lit(1, 32'h3C5A);
        lit(2, 32'd0);
        emit_word(1'b1, 16, 32'h3C5A_0000);
        emit_word(1'b0, 32, 32'h8001_FFFF);
        lit(2, 32'd1);

        // 32-bit slots keep only the MSBs
        emit_word(1'b1, 32, 32'h7FFE_0000);
        emit_word(1'b0, 16, 32'hAAAA_0000);
        lit(0, 32'h8001);
        lit(1, 32'h7FFE);
        lit(2, 32'd1);
        lit(3, 32'd0);

        // short right word
        emit_word(1'b1, 12, 32'hBBB0_0000);
        emit_word(1'b0, 16, 32'h1111_0000);
        lit(3, 32'd1);
        lit(2, 32'd0);
        lit(0, 32'h8001);
        emit_word(1'b1, 16, 32'h2222_0000);
        emit_word(1'b0, 16, 32'h3333_0000);
        lit(0, 32'h1111);
        lit(2, 32'd0);
        emit_word(1'b1, 16, 32'h4444_0000);
        emit_word(1'b0, 16, 32'h5555_0000);
        lit(2, 32'd1);
        emit_word(1'b1, 16, 32'h6666_0000);

        // sclk stops past the timeout
        repeat (TIMEOUT + 10) @(negedge clk);
        model_resync();
        lit(2, 32'd0);
        lit(0, 32'h3333);
        lit(1, 32'h4444);
        emit_word(1'b0, 16, 32'h7777_0000);
        emit_word(1'b1, 16, 32'h8888_0000);
        emit_word(1'b0, 16, 32'h9999_0000);
        lit(0, 32'h7777);
        lit(1, 32'h8888);

        // asynchronous reset in the middle of a left word
        emit_word(1'b1, 16, 32'hABCD_0000);
        emit_word(1'b0, 8, 32'hC3C3_0000);
        lit(4, 32'd0);
        @(posedge clk);
        #3 reset = 1'b1;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        model_resync();
        cur_ch  = 1'b0;
        cur_len = 0;
        emit_word(1'b0, 8, 32'h3C00_0000);
        emit_word(1'b1, 16, 32'h1357_0000);
        emit_word(1'b0, 16, 32'h2468_0000);
        lit(0, 32'h0000);
        emit_word(1'b1, 16, 32'h0F0F_0000);
        emit_word(1'b0, 16, 32'h0000_0000);
        lit(0, 32'h2468);
        lit(1, 32'h0F0F);
        lit(4, 32'd0);
        lit(3, err_exp);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
